// File: rtl/taillamp_pkg.sv
// Shared types and helpers for the tail-lamp sequencer.
// The optional TAILLAMP_DIM_EN running light uses DIM_PERIOD from here.
package taillamp_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_LEFT  = 2'd1,
        MODE_RIGHT = 2'd2,
        MODE_HAZ   = 2'd3
    } mode_t;

    localparam int unsigned DIM_PERIOD = 8;
    localparam int unsigned MASK_W     = 32;

    // Inner-first fill: bit 0 is the innermost lamp; step >= n gives all off.
    function automatic logic [MASK_W-1:0] sweep_mask(input int unsigned step, input int unsigned n);
        logic [MASK_W-1:0] m;
        m = {MASK_W{1'b0}};
        for (int unsigned i = 0; i < MASK_W; i++) begin
            m[i] = (step < n) && (i <= step);
        end
        return m;
    endfunction

endpackage

// File: rtl/taillamp_seq_step_divider.sv
// Step prescaler: emits a one-clock tick every DIV clocks unless cleared.
module step_divider #(
    parameter int DIV = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    output logic tick
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] div_r;

    // Prescale counter, held at zero while cleared
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_r <= {DW{1'b0}};
        end else if (clr) begin
            div_r <= {DW{1'b0}};
        end else if (div_r == DIV_LAST) begin
            div_r <= {DW{1'b0}};
        end else begin
            div_r <= div_r + DW'(1);
        end
    end

    assign tick = (div_r == DIV_LAST) && !clr;

endmodule

// File: rtl/taillamp_seq.sv
// Tail-lamp sequencer: turn sweep, hazard flash and brake overlay, registered outputs.
// Optional `TAILLAMP_DIM_EN adds a 1/8-duty running light for otherwise-dark lamps.
module taillamp_seq
    import taillamp_pkg::*;
#(
    parameter int N_LAMP = 3,
    parameter int DIV    = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                HAZ,
    input  logic                LEFT,
    input  logic                RIGHT,
    input  logic                BRAKE,
    output logic [2*N_LAMP-1:0] lamp
);

    localparam int SW = $clog2(N_LAMP + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(N_LAMP);

    mode_t             mode_r;
    mode_t             mode_s;
    logic              chg_s;
    logic              clr_s;
    logic              tick_s;
    logic [SW-1:0]     step_r;
    logic [SW-1:0]     step_nxt_s;
    logic              phase_r;
    logic              phase_nxt_s;
    logic              dim_s;
    logic [N_LAMP-1:0] sweep_s;
    logic [N_LAMP-1:0] sweep_rev_s;
    logic [N_LAMP-1:0] fill_s;
    logic [2*N_LAMP-1:0] lamp_nxt_s;

    // Request decode with hazard taking priority
    always_comb begin
        mode_s = MODE_IDLE;
        if (HAZ || (LEFT && RIGHT)) begin
            mode_s = MODE_HAZ;
        end else if (LEFT) begin
            mode_s = MODE_LEFT;
        end else if (RIGHT) begin
            mode_s = MODE_RIGHT;
        end else begin
            mode_s = MODE_IDLE;
        end
    end

    assign chg_s = (mode_s != mode_r);
    // IDLE keeps the prescaler parked so step/div stay at zero
    assign clr_s = chg_s || (mode_s == MODE_IDLE);

    step_divider #(.DIV(DIV)) u_div (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (clr_s),
        .tick  (tick_s)
    );

`ifdef TAILLAMP_DIM_EN
    localparam int DIM_W = $clog2(DIM_PERIOD);
    logic [DIM_W-1:0] dim_cnt_r;

    // Free-running running-light phase counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dim_cnt_r <= {DIM_W{1'b0}};
        end else begin
            dim_cnt_r <= dim_cnt_r + DIM_W'(1);
        end
    end

    assign dim_s = (dim_cnt_r == {DIM_W{1'b0}});
`else
    assign dim_s = 1'b0;
`endif

    // Next step/phase: restart on mode change, advance on prescaler tick
    always_comb begin
        step_nxt_s  = step_r;
        phase_nxt_s = phase_r;
        if (chg_s) begin
            step_nxt_s  = {SW{1'b0}};
            phase_nxt_s = 1'b1;
        end else if (tick_s) begin
            step_nxt_s  = (step_r == STEP_LAST) ? {SW{1'b0}} : step_r + SW'(1);
            phase_nxt_s = !phase_r;
        end else begin
            step_nxt_s  = step_r;
            phase_nxt_s = phase_r;
        end
    end

    // Lamp pattern from next-state values so the register holds the new pattern
    always_comb begin
        sweep_s     = N_LAMP'(sweep_mask(32'(step_nxt_s), 32'(N_LAMP)));
        sweep_rev_s = {N_LAMP{1'b0}};
        for (int i = 0; i < N_LAMP; i++) begin
            sweep_rev_s[i] = sweep_s[N_LAMP-1-i];
        end
        fill_s     = (BRAKE || dim_s) ? {N_LAMP{1'b1}} : {N_LAMP{1'b0}};
        lamp_nxt_s = {(2*N_LAMP){1'b0}};
        case (mode_s)
            MODE_LEFT:  lamp_nxt_s = {sweep_s, fill_s};
            MODE_RIGHT: lamp_nxt_s = {fill_s, sweep_rev_s};
            MODE_HAZ:   lamp_nxt_s = {(2*N_LAMP){phase_nxt_s}};
            MODE_IDLE:  lamp_nxt_s = {(2*N_LAMP){BRAKE || dim_s}};
            default:    lamp_nxt_s = {(2*N_LAMP){1'b0}};
        endcase
    end

    // Sequencer state and registered lamp drive
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_r  <= MODE_IDLE;
            step_r  <= {SW{1'b0}};
            phase_r <= 1'b1;
            lamp    <= {(2*N_LAMP){1'b0}};
        end else begin
            mode_r  <= mode_s;
            step_r  <= step_nxt_s;
            phase_r <= phase_nxt_s;
            lamp    <= lamp_nxt_s;
        end
    end

endmodule

// File: tb/tb_taillamp_seq.sv
// Scoreboard bench for taillamp_seq: two instances (3 lamps/DIV 4 and 5 lamps/DIV 1)
// driven by directed and random requests, checked against a time-based reference model.
module tb_taillamp_seq;

    localparam int N1 = 3;
    localparam int D1 = 4;
    localparam int N2 = 5;
    localparam int D2 = 1;

    logic CLK = 1'b0;
    logic RST_N;
    logic HAZ, LEFT, RIGHT, BRAKE;
    logic [2*N1-1:0] lamp1;
    logic [2*N2-1:0] lamp2;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    int md;   // reference mode: 0 idle, 1 left, 2 right, 3 hazard
    int t;    // clocks since the last mode change
    int e;    // clock edges since reset release

    always #5 CLK = ~CLK;

    taillamp_seq #(.N_LAMP(N1), .DIV(D1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .HAZ(HAZ), .LEFT(LEFT),
        .RIGHT(RIGHT), .BRAKE(BRAKE), .lamp(lamp1)
    );

    taillamp_seq #(.N_LAMP(N2), .DIV(D2)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N), .HAZ(HAZ), .LEFT(LEFT),
        .RIGHT(RIGHT), .BRAKE(BRAKE), .lamp(lamp2)
    );

    // Expected lamp word from elapsed time in the current mode.
    function automatic logic [31:0] model(input int n, input int d, input int m,
                                          input int tt, input logic b, input logic dim);
        int k;
        logic [31:0] all;
        logic [31:0] fill;
        logic [31:0] res;
        k    = (tt / d) % (n + 1);
        all  = (32'd1 << (2 * n)) - 32'd1;
        fill = (b || dim) ? ((32'd1 << n) - 32'd1) : 32'd0;
        res  = 32'd0;
        case (m)
            0: res = (b || dim) ? all : 32'd0;
            3: res = (((tt / d) % 2) == 0) ? all : 32'd0;
            1: begin
                res = fill;
                if (k < n) for (int i = 0; i <= k; i++) res[n + i] = 1'b1;
            end
            2: begin
                res = fill << n;
                if (k < n) for (int i = 0; i <= k; i++) res[n - 1 - i] = 1'b1;
            end
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    task automatic cyc(input logic h, input logic l, input logic r, input logic b);
        int m;
        logic dim;
        @(negedge CLK);
        HAZ = h; LEFT = l; RIGHT = r; BRAKE = b;
        m = (h || (l && r)) ? 3 : (l ? 1 : (r ? 2 : 0));
        if (m != md) begin
            md = m;
            t  = 0;
        end else begin
            t++;
        end
        e++;
`ifdef TAILLAMP_DIM_EN
        dim = ((e - 1) % 8) == 0;
`else
        dim = 1'b0;
`endif
        q1.push_back(model(N1, D1, md, t, b, dim));
        q2.push_back(model(N2, D2, md, t, b, dim));
    endtask

    task automatic seg(input logic h, input logic l, input logic r, input logic b, input int n);
        for (int i = 0; i < n; i++) cyc(h, l, r, b);
    endtask

    // Asynchronous reset pulse between edges; lamps must clear at once and in reset.
    task automatic rst_pulse();
        @(negedge CLK);
        #2;
        q1.push_back(32'd0); q2.push_back(32'd0);
        q1.push_back(32'd0); q2.push_back(32'd0);
        RST_N = 1'b0;
        HAZ = 1'b0; LEFT = 1'b0; RIGHT = 1'b0; BRAKE = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        md = 0; t = 0; e = 0;
    endtask

    // Monitor: compare whenever the DUT updates (clock edge or reset assertion)
    initial begin
        logic [31:0] x1, x2;
        forever begin
            @(posedge CLK or negedge RST_N);
            #1;
            if (q1.size() > 0 && q2.size() > 0) begin
                x1 = q1.pop_front();
                x2 = q2.pop_front();
                vectors++;
                if (lamp1 !== x1[2*N1-1:0]) begin
                    miscompares++;
                    $display("FAIL lamp_n3d4 t=%0t: got %b expected %b", $time, lamp1, x1[2*N1-1:0]);
                end
                if (lamp2 !== x2[2*N2-1:0]) begin
                    miscompares++;
                    $display("FAIL lamp_n5d1 t=%0t: got %b expected %b", $time, lamp2, x2[2*N2-1:0]);
                end
            end
        end
    end

    initial begin
        logic b;
        int sel, len;
        RST_N = 1'b0;
        HAZ = 1'b0; LEFT = 1'b0; RIGHT = 1'b0; BRAKE = 1'b0;
        md = 0; t = 0; e = 0;
        @(negedge CLK);
        q1.push_back(32'd0); q2.push_back(32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        seg(1'b0, 1'b1, 1'b0, 1'b0, 20);               // left sweep
        seg(1'b0, 1'b0, 1'b0, 1'b1, 3);                // idle brake
        seg(1'b0, 1'b0, 1'b1, 1'b1, 6);                // right sweep with brake
        seg(1'b0, 1'b0, 1'b1, 1'b0, 10);               // brake dropped mid-step
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, i[0]);   // hazard, brake toggling
        seg(1'b0, 1'b1, 1'b1, 1'b1, 10);               // both turns -> hazard
        seg(1'b0, 1'b0, 1'b0, 1'b0, 2);
        seg(1'b0, 1'b1, 1'b0, 1'b0, 9);                // reach step 2
        seg(1'b0, 1'b0, 1'b1, 1'b0, 5);                // switch to right
        seg(1'b1, 1'b0, 1'b0, 1'b0, 6);
        rst_pulse();
        seg(1'b0, 1'b0, 1'b0, 1'b0, 10);
        seg(1'b0, 1'b0, 1'b0, 1'b1, 2);

        b = 1'b0;
        for (int s = 0; s < 60; s++) begin
            sel = $urandom_range(0, 4);
            len = $urandom_range(1, 30);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 7) == 0) b = ~b;
                case (sel)
                    0:       cyc(1'b0, 1'b0, 1'b0, b);
                    1:       cyc(1'b0, 1'b1, 1'b0, b);
                    2:       cyc(1'b0, 1'b0, 1'b1, b);
                    3:       cyc(1'b1, 1'(j[1]), 1'(j[2]), b);
                    default: cyc(1'b0, 1'b1, 1'b1, b);
                endcase
            end
            if ($urandom_range(0, 15) == 0) rst_pulse();
        end

        @(negedge CLK);
        @(negedge CLK);
        if (q1.size() != 0 || q2.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
